// File: rtl/fast_scan_ctrl.sv
// Frame-scan sequencer for the FAST front end: steps a serpentine position generator,
// fetches each pixel from SRAM and streams it with its coordinates to the detector.
module fast_scan_ctrl #(
  parameter int SIZE   = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                abort,
  input  logic [SIZE-1:0]     img_w,
  input  logic [SIZE-1:0]     img_h,
  output logic                busy,
  output logic                frame_done,
  output logic                dim_err,
  output logic                pos_update,
  output logic                pos_new_trans,
  output logic [SIZE-1:0]     pos_max_x,
  output logic [SIZE-1:0]     pos_max_y,
  input  logic [SIZE-1:0]     pos_x,
  input  logic [SIZE-1:0]     pos_y,
  input  logic                pos_end,
  output logic                rd_req,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic                rd_ack,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                px_valid,
  input  logic                px_ready,
  output logic [DATA_W-1:0]   px_data,
  output logic [SIZE-1:0]     px_x,
  output logic [SIZE-1:0]     px_y,
  output logic [2*SIZE-1:0]   px_count
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_FETCH   = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;
  localparam logic [2:0] ST_STEP    = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam logic [2*SIZE-1:0] CNT_ONE = {{(2*SIZE-1){1'b0}}, 1'b1};

  logic [2:0]          state_r;
  logic [2:0]          state_nx_s;
  logic [SIZE-1:0]     img_w_r;
  logic [SIZE-1:0]     img_h_r;
  logic [SIZE-1:0]     cur_x_r;
  logic [SIZE-1:0]     cur_y_r;
  logic                last_r;
  logic [ADDR_W-1:0]   rd_addr_r;
  logic [DATA_W-1:0]   px_data_r;
  logic [2*SIZE-1:0]   px_count_r;
  logic                busy_r;
  logic                frame_done_r;
  logic                dim_err_r;
  logic                pos_update_r;
  logic                pos_new_trans_r;
  logic                rd_req_r;
  logic                px_valid_r;

  logic                start_acc_s;
  logic                dim_zero_s;
  logic                abort_exit_s;
  logic                px_fire_s;
  logic [ADDR_W-1:0]   addr_s;

  assign start_acc_s  = (state_r == ST_IDLE) && start;
  assign dim_zero_s   = (img_w == {SIZE{1'b0}}) || (img_h == {SIZE{1'b0}});
  assign abort_exit_s = abort && (state_r != ST_IDLE);
  assign px_fire_s    = (state_r == ST_SEND) && px_ready && !abort;
  // Row-major address of the generator position; row pitch is the latched width.
  assign addr_s = ADDR_W'(pos_y) * ADDR_W'(img_w_r) + ADDR_W'(pos_x);

  // Next-state decode; abort outranks every other transition outside IDLE.
  always_comb begin
    state_nx_s = state_r;
    if (abort_exit_s) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (dim_zero_s) begin
              state_nx_s = ST_DONE;
            end else begin
              state_nx_s = ST_CLEAR;
            end
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_CLEAR:   state_nx_s = ST_CAPTURE;
        ST_CAPTURE: state_nx_s = ST_FETCH;
        ST_FETCH: begin
          if (rd_ack) begin
            state_nx_s = ST_SEND;
          end else begin
            state_nx_s = ST_FETCH;
          end
        end
        ST_SEND: begin
          if (px_ready) begin
            if (last_r) begin
              state_nx_s = ST_DONE;
            end else begin
              state_nx_s = ST_STEP;
            end
          end else begin
            state_nx_s = ST_SEND;
          end
        end
        ST_STEP:    state_nx_s = ST_CAPTURE;
        ST_DONE:    state_nx_s = ST_IDLE;
        default:    state_nx_s = ST_IDLE;
      endcase
    end
  end

  // State and control strobes, registered from the next state so outputs carry no input paths.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r         <= ST_IDLE;
      busy_r          <= 1'b0;
      frame_done_r    <= 1'b0;
      dim_err_r       <= 1'b0;
      pos_update_r    <= 1'b0;
      pos_new_trans_r <= 1'b0;
      rd_req_r        <= 1'b0;
      px_valid_r      <= 1'b0;
    end else begin
      state_r         <= state_nx_s;
      busy_r          <= (state_nx_s != ST_IDLE);
      frame_done_r    <= (state_nx_s == ST_DONE);
      dim_err_r       <= start_acc_s && dim_zero_s;
      pos_update_r    <= (state_nx_s == ST_STEP);
      pos_new_trans_r <= (state_nx_s == ST_CLEAR) || abort_exit_s;
      rd_req_r        <= (state_nx_s == ST_FETCH);
      px_valid_r      <= (state_nx_s == ST_SEND);
    end
  end

  // Datapath: end-of-frame flag is taken once in CAPTURE since the generator wraps afterwards.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      img_w_r    <= {SIZE{1'b0}};
      img_h_r    <= {SIZE{1'b0}};
      cur_x_r    <= {SIZE{1'b0}};
      cur_y_r    <= {SIZE{1'b0}};
      last_r     <= 1'b0;
      rd_addr_r  <= {ADDR_W{1'b0}};
      px_data_r  <= {DATA_W{1'b0}};
      px_count_r <= {(2*SIZE){1'b0}};
    end else begin
      if (start_acc_s) begin
        img_w_r <= img_w;
        img_h_r <= img_h;
      end
      if ((state_r == ST_CAPTURE) && !abort) begin
        cur_x_r   <= pos_x;
        cur_y_r   <= pos_y;
        last_r    <= pos_end;
        rd_addr_r <= addr_s;
      end
      if ((state_r == ST_FETCH) && rd_ack && !abort) begin
        px_data_r <= rd_data;
      end
      if (start_acc_s) begin
        px_count_r <= {(2*SIZE){1'b0}};
      end else if (px_fire_s && !(&px_count_r)) begin
        px_count_r <= px_count_r + CNT_ONE;
      end
    end
  end

  assign busy          = busy_r;
  assign frame_done    = frame_done_r;
  assign dim_err       = dim_err_r;
  assign pos_update    = pos_update_r;
  assign pos_new_trans = pos_new_trans_r;
  assign pos_max_x     = img_w_r;
  assign pos_max_y     = img_h_r;
  assign rd_req        = rd_req_r;
  assign rd_addr       = rd_addr_r;
  assign px_valid      = px_valid_r;
  assign px_data       = px_data_r;
  assign px_x          = cur_x_r;
  assign px_y          = cur_y_r;
  assign px_count      = px_count_r;

endmodule
